// File: rtl/down_counter_timer_pkg.sv
// Shared definitions for the loadable down-counter timer: state encoding,
// default width and the all-zero count constant.
package down_counter_timer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned MAX_WIDTH     = 16;

  // Sliced to WIDTH at the point of use; wide enough for the largest legal counter.
  localparam logic [MAX_WIDTH-1:0] ZERO_COUNT = '0;

endpackage : down_counter_timer_pkg

// File: rtl/down_counter_timer.sv
// Loadable synchronous down-counter with registered terminal-count pulse and
// optional auto-reload for periodic tick generation.
module down_counter_timer
  import down_counter_timer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy
);

  localparam logic [WIDTH-1:0] CNT_ZERO = ZERO_COUNT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;

  // NOTE: every output of this block gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;

    if (load) begin
      // Load wins over counting and over tc in either state.
      count_d  = load_val;
      reload_d = load_val;
      state_d  = (load_val != CNT_ZERO) ? ST_RUN : ST_IDLE;
    end else if (state_q == ST_RUN) begin
      if (count_q == CNT_ZERO) begin
        // Zero in RUN is only reachable as the auto-reload slot; en is ignored here.
        if (auto_reload) begin
          count_d = reload_q;
        end else begin
          state_d = ST_IDLE;
        end
      end else if (en) begin
        if (count_q == CNT_ONE) begin
          count_d = CNT_ZERO;
          tc_d    = 1'b1;
          state_d = auto_reload ? ST_RUN : ST_IDLE;
        end else begin
          count_d = count_q - CNT_ONE;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values computed above.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      count_q  <= CNT_ZERO;
      reload_q <= CNT_ZERO;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign busy  = (state_q == ST_RUN);

endmodule : down_counter_timer

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer: a table of per-cycle vectors
// plus hand-written reset-abort and full-range wrap sequences.
module tb_down_counter_timer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic [W-1:0] load_val;
  logic         en;
  logic         auto_reload;
  logic [W-1:0] count;
  logic         tc;
  logic         busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic         ld;
    logic [W-1:0] val;
    logic         en;
    logic         ar;
    logic [W-1:0] cnt;
    logic         tc;
    logic         busy;
  } vec_t;

  typedef struct {
    int           tag;
    logic [W-1:0] cnt;
    logic         tc;
    logic         busy;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  down_counter_timer #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .load_val    (load_val),
    .en          (en),
    .auto_reload (auto_reload),
    .count       (count),
    .tc          (tc),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int tag, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d: got %0d, expected %0d", name, tag, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ld, input logic [W-1:0] val, input logic e,
                              input logic ar, input logic [W-1:0] c, input logic t,
                              input logic b);
    vec_t v;
    v.ld = ld; v.val = val; v.en = e; v.ar = ar;
    v.cnt = c; v.tc = t; v.busy = b;
    return v;
  endfunction

  // Called at a negedge: drive inputs, queue the expectation, compare at the next negedge.
  task automatic step(input int tag, input logic ld, input logic [W-1:0] val,
                      input logic e, input logic ar, input logic [W-1:0] c,
                      input logic t, input logic b);
    exp_t x;
    load = ld; load_val = val; en = e; auto_reload = ar;
    x.tag = tag; x.cnt = c; x.tc = t; x.busy = b;
    sb.push_back(x);
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      check("scoreboard_empty", tag, 32'd0, 32'd1);
    end else begin
      x = sb.pop_front();
      check("count", x.tag, 32'(count), 32'(x.cnt));
      check("tc",    x.tag, 32'(tc),    32'(x.tc));
      check("busy",  x.tag, 32'(busy),  32'(x.busy));
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; load_val = '0; en = 1'b0; auto_reload = 1'b0;

    //            ld val en ar  cnt tc busy
    // one-shot from 3
    vecs.push_back(mk(1, 3, 1, 0, 3, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 2, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0));
    // enable gating
    vecs.push_back(mk(1, 2, 0, 0, 2, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 2, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 2, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 2, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0));
    // auto-reload, period 3; en low on a reload cycle is ignored
    vecs.push_back(mk(1, 2, 1, 1, 2, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, 2, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 1, 2, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 1, 1));
    // auto_reload dropped while at zero in RUN -> IDLE, count stays 0
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0));
    // load priority at count==1
    vecs.push_back(mk(1, 3, 1, 0, 3, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 2, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 1));
    vecs.push_back(mk(1, 7, 1, 0, 7, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 6, 0, 1));
    // load of zero in RUN -> IDLE, no tc
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0));
    // load of zero in IDLE -> stays IDLE, no tc
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0));

    // reset state
    @(negedge clk);
    check("reset_count", 0, 32'(count), 32'd0);
    check("reset_tc",    0, 32'(tc),    32'd0);
    check("reset_busy",  0, 32'(busy),  32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(i, vecs[i].ld, vecs[i].val, vecs[i].en, vecs[i].ar,
           vecs[i].cnt, vecs[i].tc, vecs[i].busy);
    end

    // full-range load: tc exactly 15 cycles after the load cycle
    step(100, 1'b1, 4'd15, 1'b1, 1'b0, 4'd15, 1'b0, 1'b1);
    for (int i = 1; i <= 15; i++) begin
      step(100 + i, 1'b0, 4'd0, 1'b1, 1'b0, W'(15 - i), (i == 15), (i != 15));
    end

    // asynchronous reset mid-count at 5
    step(200, 1'b1, 4'd9, 1'b1, 1'b0, 4'd9, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      step(200 + i, 1'b0, 4'd0, 1'b1, 1'b0, W'(9 - i), 1'b0, 1'b1);
    end
    #2 rst = 1'b1;
    #1;
    check("abort_count", 210, 32'(count), 32'd0);
    check("abort_busy",  210, 32'(busy),  32'd0);
    check("abort_tc",    210, 32'(tc),    32'd0);
    @(posedge clk);
    #1;
    check("held_count", 211, 32'(count), 32'd0);
    check("held_busy",  211, 32'(busy),  32'd0);
    check("held_tc",    211, 32'(tc),    32'd0);
    @(negedge clk);
    rst = 1'b0;
    step(212, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    // reload register was cleared by reset: a fresh load still works
    step(213, 1'b1, 4'd1, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1);
    step(214, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);

    if (sb.size() != 0) check("scoreboard_leftover", 999, 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_down_counter_timer

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
Synchronous, loadable down-counter. Counts from a loaded value to zero, then flags terminal count.
It is the count-down counterpart to the team's ripple up-counter. Used as a programmable delay/timeout source for neighbouring control blocks.
All flops share one clock, so there is no ripple clocking. The optional auto-reload mode gives a periodic tick generator.

Parameters:
WIDTH, 4, counter width in bits (legal 2..16)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
load  input  1  load request, single-cycle pulse or level
load_val  input  WIDTH  value captured on load; also the reload value in auto-reload mode
en  input  1  count enable; the count decrements only when en=1
auto_reload  input  1  1 = on reaching zero, reload the stored value and keep running; 0 = stop at zero
count  output  WIDTH  current counter value
tc  output  1  terminal-count pulse, one cycle wide
busy  output  1  high while in RUN state

Behaviour:
- Reset: asynchronous and active-high. It is decided that reset is applied on rst assertion and released synchronously by the design's reset controller.
  - While rst=1: state=IDLE, count=0, reload register=0, tc=0, busy=0.
  - Reset mid-count aborts immediately. There is no tc on abort.
- Reload register: holds load_val, captured on every cycle where load=1.
- States: IDLE and RUN. busy=1 exactly in RUN.
- IDLE:
  - load=1: count<=load_val, reload register<=load_val.
    - If load_val!=0, the next state is RUN.
    - If load_val==0, stay in IDLE and do not pulse tc.
  - load=0: hold.
- RUN, with load=1: load has priority over counting and over tc.
  - count<=load_val, reload register<=load_val, no tc.
  - If load_val==0, go to IDLE.
- RUN, with load=0 and en=0: hold count and state. tc=0.
- RUN, with load=0, en=1 and count>1: count<=count-1.
- RUN, with load=0, en=1 and count==1 (final step):
  - count<=0 and tc<=1 on the next cycle, so tc is registered and aligned with count becoming 0.
  - If auto_reload=0: next state is IDLE.
  - If auto_reload=1: the next cycle loads the reload register into count and stays in RUN, so period = reload+1 enabled cycles (count visits 0 for one cycle).
- RUN, auto-reload cycle (count==0, auto_reload=1): count<=reload register and tc<=0. en is ignored for this single reload cycle.
  - If auto_reload drops while count==0 in RUN, go to IDLE next cycle and keep count=0.
- tc: never asserted for two consecutive cycles. Only the RUN-to-zero transition asserts it.
- Arithmetic: unsigned modulo-2^WIDTH.
  - Decrement never underflows because the count==1 step is handled explicitly.
  - A count of 0 is never decremented.
- Latency: load to count visible is 1 cycle. From load of N with en held high, tc asserts N cycles after the load cycle.
- Outputs are all registered. There is no combinational path from inputs to outputs.

Decomposition:
- Shared counter package holds:
  - the state enum (IDLE=1'b0, RUN=1'b1);
  - the default WIDTH constant;
  - a helper constant for the all-zero count.
- No sub-module. A single always_ff block for state/count/tc plus next-state logic is natural at this size.
- No reuse of the toggle-flop cell, since this block is fully synchronous.

Test Plan:
- Reset: assert rst mid-RUN at count=5 -> count=0, busy=0, tc=0 immediately (asynchronous), and stay so until rst drops.
- One-shot: load 4'd3 with en=1, auto_reload=0 -> count 3,2,1,0 on successive cycles; tc=1 in the cycle count=0; then IDLE, busy=0, count holds 0.
- Enable gating: load 4'd2 then en=0 for 3 cycles, then en=1 -> count holds 2 for 3 cycles, then 1, 0; tc=1 once.
- Auto-reload: load 4'd2, en=1, auto_reload=1, run 9 cycles -> count 2,1,0,2,1,0,2,1,0; tc pulses every 3rd cycle; busy stays 1.
- Load priority: in RUN at count=1 with en=1, assert load with load_val=4'd7 -> count=7 next cycle, tc stays 0, still RUN.
- Zero load and wrap: load 4'd0 -> stays IDLE, no tc. Load 4'd15 (max, WIDTH=4) with en=1 -> 15 decrements to 0, tc after exactly 15 cycles.
